// File: rtl/fp_add_pkg.sv
// Shared types and width helpers for the parametrised floating-point adder.
package fp_add_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      ADD,
      NORM,
      ROUND,
      DONE
   } state_t;

   // Working significand: {carry, hidden, mantissa, guard, round, sticky}.
   function automatic int sig_w(input int man_w);
      return man_w + 5;
   endfunction

   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

   // The counter sees the significand without its carry bit.
   function automatic int lzc_w(input int man_w);
      return cnt_w(man_w + 4);
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc
   import fp_add_pkg::*;
#(
   parameter int WIDTH = 7,
   parameter int CNT_W = cnt_w(WIDTH)
) (
   input  logic [WIDTH-1:0] din,
   output logic [CNT_W-1:0] cnt
);

   logic found;

   always_comb begin
      cnt   = CNT_W'(WIDTH);
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found && din[i]) begin
            cnt   = CNT_W'(WIDTH - 1 - i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_add_param.sv
// Sequential floating-point adder/subtractor with valid/ready handshake,
// GRS alignment, leading-zero normalisation and round-to-nearest-even.
module fp_add_param
   import fp_add_pkg::*;
#(
   parameter int EXP_W = 4,
   parameter int MAN_W = 3,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] s,
   output logic         ovf,
   output logic         unf,
   output logic         inexact
);

   localparam int SIG_W = sig_w(MAN_W);
   localparam int LZC_W = lzc_w(MAN_W);
   // Exponent headroom covers carry/round increments and the full lzc decrement.
   localparam int EC_W  = EXP_W + LZC_W + 2;
   localparam logic signed [EC_W-1:0] EXP_MAX = EC_W'((1 << EXP_W) - 1);
   localparam logic signed [EC_W-1:0] EXP_ONE = EC_W'(1);

   function automatic logic [SIG_W-1:0] align_shift(input logic [SIG_W-1:0] sig,
                                                   input logic [EXP_W-1:0] sh);
      logic [SIG_W-1:0] res;
      logic             st;
      st = 1'b0;
      if (int'(sh) >= MAN_W + 3) begin
         res    = '0;
         res[0] = |sig;
      end else begin
         res = sig >> sh;
         for (int i = 0; i < SIG_W; i++) begin
            if (i < int'(sh)) st = st | sig[i];
         end
         res[0] = res[0] | st;
      end
      return res;
   endfunction

   function automatic logic rne_inc(input logic lsb, input logic g,
                                    input logic r, input logic st);
      return g & (r | st | lsb);
   endfunction

   // Packs {s, ovf, unf, inexact}, saturating or flushing out-of-range exponents.
   function automatic logic [W+2:0] finish_result(input logic sgn,
                                                  input logic signed [EC_W-1:0] e,
                                                  input logic [MAN_W-1:0] m,
                                                  input logic inx);
      if (e > EXP_MAX)
         return {sgn, {(W-1){1'b1}}, 1'b1, 1'b0, 1'b1};
      else if (e < EXP_ONE)
         return {sgn, {(W-1){1'b0}}, 1'b0, 1'b1, 1'b1};
      else
         return {sgn, e[EXP_W-1:0], m, 1'b0, 1'b0, inx};
   endfunction

   state_t state, state_nxt;
   logic   accept, done_hs;

   logic [W-1:0]             a_r;
   logic [W-2:0]             b_mag_r;
   logic                     sbe_r;
   logic                     sign_r, eff_sub_r, special_r, zero_r;
   logic [W-1:0]             special_s_r;
   logic signed [EC_W-1:0]   exp_r, exp_n_r;
   logic [SIG_W-1:0]         sig_l_r, sig_s_r, sum_r;
   logic [SIG_W-2:0]         sig_n_r;
   logic [LZC_W-1:0]         lzc;

   logic [EXP_W-1:0] exp_a, exp_b, exp_l, exp_s, exp_diff;
   logic [MAN_W-1:0] man_l, man_s;
   logic             zero_a, zero_b, a_big, sign_a, sign_l;
   logic [W-1:0]     special_s;

   logic                   inx, inc, rnd_carry;
   logic [MAN_W+1:0]       mant_ext;
   logic [MAN_W-1:0]       man_f;
   logic signed [EC_W-1:0] exp_f;
   logic [W+2:0]           rnd_res;

   assign accept  = in_valid & in_ready;
   assign done_hs = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ALIGN;
         ALIGN:   state_nxt = ADD;
         ADD:     state_nxt = NORM;
         NORM:    state_nxt = ROUND;
         ROUND:   state_nxt = DONE;
         DONE:    if (done_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ALIGN: order operands by magnitude (ties keep a) and pick the zero-operand result
   always_comb begin
      exp_a    = a_r[W-2:MAN_W];
      exp_b    = b_mag_r[W-2:MAN_W];
      sign_a   = a_r[W-1];
      zero_a   = (exp_a == '0);
      zero_b   = (exp_b == '0);
      a_big    = (a_r[W-2:0] >= b_mag_r);
      exp_l    = a_big ? exp_a : exp_b;
      exp_s    = a_big ? exp_b : exp_a;
      man_l    = a_big ? a_r[MAN_W-1:0] : b_mag_r[MAN_W-1:0];
      man_s    = a_big ? b_mag_r[MAN_W-1:0] : a_r[MAN_W-1:0];
      sign_l   = a_big ? sign_a : sbe_r;
      exp_diff = exp_l - exp_s;
      special_s = '0;
      if (zero_a && zero_b)
         special_s = {sign_a & sbe_r, {(W-1){1'b0}}};
      else if (zero_a)
         special_s = {sbe_r, b_mag_r};
      else if (zero_b)
         special_s = a_r;
   end

   fp_lzc #(
      .WIDTH (SIG_W - 1),
      .CNT_W (LZC_W)
   ) u_lzc (
      .din (sum_r[SIG_W-2:0]),
      .cnt (lzc)
   );

   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (accept) begin
               a_r     <= a;
               b_mag_r <= b[W-2:0];
               sbe_r   <= b[W-1] ^ sub;
            end
         end
         ALIGN: begin
            sign_r      <= sign_l;
            eff_sub_r   <= sign_a ^ sbe_r;
            special_r   <= zero_a | zero_b;
            special_s_r <= special_s;
            exp_r       <= $signed({{(EC_W-EXP_W){1'b0}}, exp_l});
            sig_l_r     <= {2'b01, man_l, 3'b000};
            sig_s_r     <= align_shift({2'b01, man_s, 3'b000}, exp_diff);
         end
         ADD: begin
            sum_r <= eff_sub_r ? (sig_l_r - sig_s_r) : (sig_l_r + sig_s_r);
         end
         NORM: begin
            zero_r <= (sum_r == '0);
            if (sum_r[SIG_W-1]) begin
               sig_n_r <= {sum_r[SIG_W-1:2], sum_r[1] | sum_r[0]};
               exp_n_r <= exp_r + EXP_ONE;
            end else begin
               sig_n_r <= sum_r[SIG_W-2:0] << lzc;
               exp_n_r <= exp_r - $signed({{(EC_W-LZC_W){1'b0}}, lzc});
            end
         end
         default: ;
      endcase
   end

   // ROUND: nearest-even on G/R/S; a mantissa carry-out renormalises to 1.0
   always_comb begin
      inx       = |sig_n_r[2:0];
      inc       = rne_inc(sig_n_r[3], sig_n_r[2], sig_n_r[1], sig_n_r[0]);
      mant_ext  = {1'b0, sig_n_r[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, inc};
      rnd_carry = mant_ext[MAN_W+1];
      man_f     = rnd_carry ? mant_ext[MAN_W:1] : mant_ext[MAN_W-1:0];
      exp_f     = rnd_carry ? (exp_n_r + EXP_ONE) : exp_n_r;
      if (special_r)
         rnd_res = {special_s_r, 3'b000};
      else if (zero_r)
         rnd_res = '0;
      else
         rnd_res = finish_result(sign_r, exp_f, man_f, inx);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         s         <= '0;
         ovf       <= 1'b0;
         unf       <= 1'b0;
         inexact   <= 1'b0;
      end else begin
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
         if (state == ROUND) {s, ovf, unf, inexact} <= rnd_res;
      end
   end

endmodule

// File: tb/tb_fp_add_param.sv
// Scoreboard bench for fp_add_param at EXP_W=4, MAN_W=3 (bias 7).
module tb_fp_add_param;

   localparam int EXP_W = 4;
   localparam int MAN_W = 3;
   localparam int W     = 1 + EXP_W + MAN_W;

   typedef struct packed {
      logic [7:0] s;
      logic       ovf;
      logic       unf;
      logic       inx;
   } res_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic [7:0] s;
      logic [2:0] f;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] s;
   logic         ovf, unf, inexact;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   res_t sb_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fp_add_param #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .ovf       (ovf),
      .unf       (unf),
      .inexact   (inexact)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // pre_cyc is the cycle count just before the accepting edge.
   task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic xsub,
                       input res_t exp_res, input bit push, output int pre_cyc, output bit ok);
      a = xa; b = xb; sub = xsub; in_valid = 1'b1;
      ok = 1'b0; pre_cyc = 0;
      for (int i = 0; i < 40; i++) begin
         if (in_ready) begin
            pre_cyc = cyc;
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (ok && push) sb_q.push_back(exp_res);
   endtask

   task automatic wait_out(output int out_cyc, output bit ok);
      ok = 1'b0; out_cyc = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            out_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({in_ready, out_valid, s, ovf, unf, inexact} !== 13'h0) begin
         n_fail++;
         $display("FAIL reset_vals: got rdy=%b vld=%b s=%h f=%b%b%b, want all zero",
                  in_ready, out_valid, s, ovf, unf, inexact);
      end
      rst_n = 1'b1;
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_early: in_ready got %b want 0", in_ready);
      end
      @(posedge clk); #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: in_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_arith();
      vec_t tbl[13];
      res_t e;
      int   pre, oc;
      bit   ok;
      // expected flags are {ovf, unf, inexact}
      tbl[0]  = {8'h38, 8'h38, 1'b0, 8'h40, 3'b000};
      tbl[1]  = {8'h38, 8'h38, 1'b1, 8'h00, 3'b000};
      tbl[2]  = {8'h38, 8'h00, 1'b0, 8'h38, 3'b000};
      tbl[3]  = {8'h38, 8'h18, 1'b0, 8'h38, 3'b001};
      tbl[4]  = {8'h38, 8'h24, 1'b0, 8'h3A, 3'b001};
      tbl[5]  = {8'h7F, 8'h7F, 1'b0, 8'h7F, 3'b101};
      tbl[6]  = {8'h09, 8'h08, 1'b1, 8'h00, 3'b011};
      tbl[7]  = {8'h40, 8'h38, 1'b1, 8'h38, 3'b000};
      tbl[8]  = {8'h00, 8'h38, 1'b1, 8'hB8, 3'b000};
      tbl[9]  = {8'h80, 8'h00, 1'b1, 8'h80, 3'b000};
      tbl[10] = {8'hB8, 8'h38, 1'b0, 8'h00, 3'b000};
      tbl[11] = {8'h38, 8'h48, 1'b0, 8'h4A, 3'b000};
      tbl[12] = {8'h3F, 8'h1F, 1'b0, 8'h40, 3'b001};
      out_ready = 1'b1;
      for (int k = 0; k < 13; k++) begin
         send(tbl[k].a, tbl[k].b, tbl[k].sub, {tbl[k].s, tbl[k].f}, 1'b1, pre, ok);
         n_tests++;
         if (!ok) begin
            n_fail++;
            $display("FAIL arith_accept[%0d]: in_ready never high", k);
            continue;
         end
         wait_out(oc, ok);
         n_tests++;
         if (!ok) begin
            n_fail++;
            $display("FAIL arith_timeout[%0d]: out_valid never rose", k);
            void'(sb_q.pop_front());
            continue;
         end
         // Five state transitions, the accepting edge being the first.
         n_tests++;
         if (oc - pre !== 5) begin
            n_fail++;
            $display("FAIL arith_latency[%0d]: got %0d edges want 5", k, oc - pre);
         end
         e = sb_q.pop_front();
         n_tests++;
         if ({s, ovf, unf, inexact} !== e) begin
            n_fail++;
            $display("FAIL arith_result[%0d] %h op%b %h: got s=%h f=%b%b%b want s=%h f=%b%b%b",
                     k, tbl[k].a, tbl[k].sub, tbl[k].b, s, ovf, unf, inexact,
                     e.s, e.ovf, e.unf, e.inx);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      res_t e;
      int   pre, oc;
      bit   ok;
      out_ready = 1'b0;
      send(8'h38, 8'h38, 1'b0, {8'h40, 3'b000}, 1'b1, pre, ok);
      wait_out(oc, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL bp_timeout: out_valid never rose");
         out_ready = 1'b1;
         sb_q.delete();
         return;
      end
      e = sb_q.pop_front();
      a = 8'h40; b = 8'h38; sub = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if ({out_valid, in_ready, s, ovf, unf, inexact} !== {1'b1, 1'b0, e}) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b s=%h f=%b%b%b want vld=1 rdy=0 s=%h f=%b%b%b",
                     i, out_valid, in_ready, s, ovf, unf, inexact, e.s, e.ovf, e.unf, e.inx);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n_tests++;
      if ({out_valid, s} !== {1'b1, e.s}) begin
         n_fail++;
         $display("FAIL bp_still_valid: got vld=%b s=%h want vld=1 s=%h", out_valid, s, e.s);
      end
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_no_accept: in_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_back_to_back();
      res_t e;
      int   pre1, pre2, oc;
      bit   ok;
      out_ready = 1'b1;
      send(8'h40, 8'h38, 1'b1, {8'h38, 3'b000}, 1'b1, pre1, ok);
      wait_out(oc, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL b2b_timeout1: out_valid never rose");
         sb_q.delete();
         return;
      end
      e = sb_q.pop_front();
      n_tests++;
      if ({s, ovf, unf, inexact} !== e) begin
         n_fail++;
         $display("FAIL b2b_result1: got s=%h f=%b%b%b want s=%h f=%b%b%b",
                  s, ovf, unf, inexact, e.s, e.ovf, e.unf, e.inx);
      end
      @(posedge clk); #1;
      n_tests++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL b2b_handshake: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
      end
      send(8'h38, 8'h48, 1'b0, {8'h4A, 3'b000}, 1'b1, pre2, ok);
      n_tests++;
      if (pre2 - pre1 !== 6) begin
         n_fail++;
         $display("FAIL b2b_interval: got %0d cycles want 6", pre2 - pre1);
      end
      wait_out(oc, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL b2b_timeout2: out_valid never rose");
         sb_q.delete();
         return;
      end
      e = sb_q.pop_front();
      n_tests++;
      if ({s, ovf, unf, inexact} !== e) begin
         n_fail++;
         $display("FAIL b2b_result2: got s=%h f=%b%b%b want s=%h f=%b%b%b",
                  s, ovf, unf, inexact, e.s, e.ovf, e.unf, e.inx);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int pre, seen;
      bit ok;
      out_ready = 1'b1;
      send(8'h38, 8'h38, 1'b0, {8'h40, 3'b000}, 1'b0, pre, ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL rmid_accept: in_ready never high");
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({in_ready, out_valid, s, ovf, unf, inexact} !== 13'h0) begin
         n_fail++;
         $display("FAIL rmid_reset_vals: got rdy=%b vld=%b s=%h f=%b%b%b, want all zero",
                  in_ready, out_valid, s, ovf, unf, inexact);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_release_early: in_ready got %b want 0", in_ready);
      end
      @(posedge clk); #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_release_ready: in_ready got %b want 1", in_ready);
      end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) seen++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (seen !== 0 || sb_q.size() !== 0) begin
         n_fail++;
         $display("FAIL rmid_discard: out_valid cycles got %0d want 0, queue %0d want 0",
                  seen, sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
